alu_exec_unit: RTL

//  Execute stage consuming the 4-bit ALUControl code from the ALU decoder plus two 32-bit operands.

---
 rtl/alu_exec_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU with valid/ready handshakes on both sides and
//            a one-entry result register feeding writeback/branch logic.
//            Logical/arithmetic ops finish in one cycle. Shifts step one bit
//            per cycle unless ALU_FAST_SHIFT_EN is defined, in which case a
//            combinational barrel shifter gives every op a latency of one.
// Config   : `define ALU_FAST_SHIFT_EN  -> barrel shifter, SHIFT state unused
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    // ALUControl encodings from the decoder
    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_sll  = 4'b0101;
    localparam logic [3:0] c_op_srl  = 4'b0110;
    localparam logic [3:0] c_op_sra  = 4'b0111;
    localparam logic [3:0] c_op_slt  = 4'b1000;
    localparam logic [3:0] c_op_sltu = 4'b1001;
    localparam logic [3:0] c_op_lui  = 4'b1010;
    localparam logic [3:0] c_op_xori = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;

    logic              w_accept;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]   w_op_result;
    logic              w_iter_start;   // accepted op needs the iterative shifter
    logic              w_iter_last;    // final shift step happens this cycle
    logic [XLEN-1:0]   w_iter_value;   // value produced by the final shift step

    assign w_shamt   = src_b[SHAMT_W-1:0];

    // A new op can enter when idle, or when the held result leaves this cycle
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // Single-cycle result for the op presented on the input port
    always_comb begin
        w_op_result = '0;
        case (alu_control)
            c_op_add:           w_op_result = src_a + src_b;
            c_op_sub:           w_op_result = src_a - src_b;
            c_op_and:           w_op_result = src_a & src_b;
            c_op_or:            w_op_result = src_a | src_b;
            c_op_xor, c_op_xori: w_op_result = src_a ^ src_b;
            c_op_slt:           w_op_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_op_sltu:          w_op_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            c_op_lui:           w_op_result = src_b;
`ifdef ALU_FAST_SHIFT_EN
            c_op_sll:           w_op_result = src_a << w_shamt;
            c_op_srl:           w_op_result = src_a >> w_shamt;
            c_op_sra:           w_op_result = $signed(src_a) >>> w_shamt;
`else
            // Only reaches the result register when shamt is zero;
            // non-zero amounts go through the iterative shifter.
            c_op_sll, c_op_srl, c_op_sra: w_op_result = src_a;
`endif
            default:            w_op_result = '0;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [XLEN-1:0]    w_acc_step;

    function automatic logic f_is_shift(input logic [3:0] op);
        return (op == c_op_sll) || (op == c_op_srl) || (op == c_op_sra);
    endfunction

    assign w_iter_start = f_is_shift(alu_control) && (w_shamt != '0);
    assign w_iter_last  = (state_q == S_SHIFT) && (cnt_q == SHAMT_W'(1));
    assign w_iter_value = w_acc_step;

    // One-bit shift of the accumulator in the direction/fill of the latched op
    always_comb begin
        w_acc_step = acc_q;
        case (op_q)
            c_op_sll: w_acc_step = {acc_q[XLEN-2:0], 1'b0};
            c_op_srl: w_acc_step = {1'b0, acc_q[XLEN-1:1]};
            default:  w_acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
        endcase
    end

    // Load the shifter on accept, then step it once per SHIFT cycle
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (w_accept && w_iter_start) begin
            acc_d = src_a;
            cnt_d = w_shamt;
            op_d  = alu_control;
        end else if (state_q == S_SHIFT) begin
            acc_d = w_acc_step;
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    // Shifter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end
`else
    assign w_iter_start = 1'b0;
    assign w_iter_last  = 1'b0;
    assign w_iter_value = '0;
`endif

    // Next-state and result-register update
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
                if (w_accept) begin
                    if (w_iter_start) begin
                        state_d = S_SHIFT;
                    end else begin
                        result_d = w_op_result;
                        zero_d   = (w_op_result == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (w_iter_last) begin
                    result_d = w_iter_value;
                    zero_d   = (w_iter_value == '0);
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule
`default_nettype wire
